seq_divider: RTL and testbench

Unsigned restoring divider, one quotient bit per clock. Sits directly downstream of the operand registers and instantiates the team's adder_subtractor at width N+1 as its trial-subtraction datapath: it feeds `a`, `b` and `sub=1` to the adder_subtractor, then consumes `y` and `carry_out` each iteration. Start/busy/done handshake, so a controller can issue one division at a time.

---
 rtl/div_pkg.sv | 15 +
 rtl/adder_subtractor.sv | 23 ++
 rtl/seq_divider.sv | 108 ++++++++++
 tb/tb_seq_divider.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// the iteration-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adder_subtractor.sv
// N-bit adder/subtractor: y = a + b (sub=0) or a - b (sub=1).
// carry_out is the unsigned carry (no borrow when subtracting); overflow is the signed overflow.
module adder_subtractor #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y,
  output logic         carry_out,
  output logic         overflow
);

  logic [N-1:0] b_eff;
  logic [N:0]   sum;

  assign b_eff     = b ^ {N{sub}};
  assign sum       = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
  assign y         = sum[N-1:0];
  assign carry_out = sum[N];
  assign overflow  = (a[N-1] == b_eff[N-1]) && (y[N-1] != a[N-1]);

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, with start/busy/done
// handshake. Results and div_by_zero are registered and held between completions.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  d_q;
  logic [N-1:0]  r_q;
  logic          dbz_q;

  logic [N:0]    shifted_d;
  logic [N:0]    diff_d;
  logic          no_borrow_d;
  logic          ovf_unused;
  logic          diff_msb_unused;

  assign shifted_d = {r_q, q_q[N-1]};

  adder_subtractor #(.N(N + 1)) u_trial (
    .a         (shifted_d),
    .b         ({1'b0, d_q}),
    .sub       (1'b1),
    .y         (diff_d),
    .carry_out (no_borrow_d),
    .overflow  (ovf_unused)
  );

  // A successful trial leaves a difference below d, so its top bit is always 0.
  assign diff_msb_unused = diff_d[N];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            q_q   <= dividend;
            d_q   <= divisor;
            r_q   <= '0;
            cnt_q <= CW'(N);
            if (divisor == '0) begin
              dbz_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              dbz_q   <= 1'b0;
              busy    <= 1'b1;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (no_borrow_d) begin
            r_q <= diff_d[N-1:0];
            q_q <= {q_q[N-2:0], 1'b1};
          end else begin
            r_q <= shifted_d[N-1:0];
            q_q <= {q_q[N-2:0], 1'b0};
          end
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            busy    <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // On divide-by-zero no iterations ran, so q_q still holds the dividend.
          done        <= 1'b1;
          quotient    <= dbz_q ? '1 : q_q;
          remainder   <= dbz_q ? q_q : r_q;
          div_by_zero <= dbz_q;
          state_q     <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=8): directed scenarios plus a
// randomized back-to-back sweep against an arithmetic reference model.
module tb_seq_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference model: plain arithmetic, with the divide-by-zero convention.
  function automatic logic [3*N:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] rq, rr;
    if (b == 0) begin
      rq = {N{1'b1}};
      rr = a;
      return {rq, rr, 1'b1, {N{1'b0}}};
    end
    rq = N'(a / b);
    rr = N'(a % b);
    return {rq, rr, 1'b0, {N{1'b0}}};
  endfunction

  // Drive start for one cycle; returns on the falling edge right after the accept edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // k = rising edges after the accept edge when done is first seen.
  task automatic wait_done(output int k, output int nbusy);
    k = 0; nbusy = 0;
    while (!done && k < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b exp 0", done); else passes++;
    checks++; if (quotient !== '0 || remainder !== '0)
      $display("FAIL reset_results got q=%0d r=%0d exp 0/0", quotient, remainder); else passes++;
    checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %0b exp 0", div_by_zero); else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int k, nb;
    issue(8'd100, 8'd7);
    wait_done(k, nb);
    checks++; if (k != N + 1) $display("FAIL basic_latency got %0d exp %0d", k, N + 1); else passes++;
    checks++; if (nb != N) $display("FAIL basic_busy_cycles got %0d exp %0d", nb, N); else passes++;
    checks++; if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0)
      $display("FAIL basic_result got q=%0d r=%0d z=%0b exp 14/2/0", quotient, remainder, div_by_zero);
    else passes++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %0b exp 0", done); else passes++;
  endtask

  task automatic test_extremes;
    logic [N-1:0] ta [2] = '{8'd255, 8'd3};
    logic [N-1:0] tb [2] = '{8'd1, 8'd200};
    logic [N-1:0] eq [2] = '{8'd255, 8'd0};
    logic [N-1:0] er [2] = '{8'd0, 8'd3};
    int k, nb;
    for (int i = 0; i < 2; i++) begin
      issue(ta[i], tb[i]);
      wait_done(k, nb);
      checks++; if (quotient !== eq[i] || remainder !== er[i] || k != N + 1)
        $display("FAIL extreme_%0d got q=%0d r=%0d k=%0d exp %0d/%0d k=%0d",
                 i, quotient, remainder, k, eq[i], er[i], N + 1);
      else passes++;
    end
  endtask

  task automatic test_div_zero;
    int k, nb;
    issue(8'd5, 8'd0);
    wait_done(k, nb);
    checks++; if (k != 1 || nb != 0) $display("FAIL dz_timing got k=%0d busy=%0d exp 1/0", k, nb); else passes++;
    checks++; if (quotient !== 8'd255 || remainder !== 8'd5 || div_by_zero !== 1'b1)
      $display("FAIL dz_result got q=%0d r=%0d z=%0b exp 255/5/1", quotient, remainder, div_by_zero);
    else passes++;
    issue(8'd100, 8'd7);
    checks++; if (div_by_zero !== 1'b1 || quotient !== 8'd255)
      $display("FAIL dz_hold got q=%0d z=%0b exp 255/1", quotient, div_by_zero); else passes++;
    wait_done(k, nb);
    checks++; if (div_by_zero !== 1'b0 || quotient !== 8'd14)
      $display("FAIL dz_clear got q=%0d z=%0b exp 14/0", quotient, div_by_zero); else passes++;
  endtask

  task automatic test_start_ignored;
    int k, ndone;
    issue(8'd200, 8'd9);
    k = 0;
    while (!done && k < 40) begin
      if (k == 3) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      end else start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    checks++; if (k != N + 1 || quotient !== 8'd22 || remainder !== 8'd2)
      $display("FAIL ignored_result got q=%0d r=%0d k=%0d exp 22/2 k=%0d", quotient, remainder, k, N + 1);
    else passes++;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++; if (ndone != 0 || quotient !== 8'd22)
      $display("FAIL ignored_no_second got dones=%0d q=%0d exp 0/22", ndone, quotient); else passes++;
  endtask

  task automatic test_reset_mid;
    int k, nb, ndone;
    issue(8'd77, 8'd4);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0)
      $display("FAIL midreset_outputs got b=%0b d=%0b q=%0d r=%0d z=%0b exp all 0",
               busy, done, quotient, remainder, div_by_zero);
    else passes++;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++; if (ndone != 0) $display("FAIL midreset_quiet got active_cycles=%0d exp 0", ndone); else passes++;
    issue(8'd77, 8'd4);
    wait_done(k, nb);
    checks++; if (quotient !== 8'd19 || remainder !== 8'd1 || k != N + 1)
      $display("FAIL midreset_rerun got q=%0d r=%0d k=%0d exp 19/1 k=%0d", quotient, remainder, k, N + 1);
    else passes++;
  endtask

  function automatic logic [N-1:0] pick_operand();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return '0;
    if (sel == 1) return '1;
    return N'($urandom);
  endfunction

  task automatic test_random_sweep;
    logic [N-1:0] a, b;
    logic [3*N:0] exp_v;
    int k, nb, gap, exp_gap;
    a = pick_operand(); b = pick_operand();
    issue(a, b);
    wait_done(k, nb);
    for (int i = 0; i < 2000; i++) begin
      exp_v = ref_div(a, b);
      checks++;
      if (!done || quotient !== exp_v[3*N:2*N+1] || remainder !== exp_v[2*N:N+1] || div_by_zero !== exp_v[N])
        $display("FAIL sweep_%0d %0d/%0d got q=%0d r=%0d z=%0b exp %0d/%0d/%0b", i, a, b,
                 quotient, remainder, div_by_zero, exp_v[3*N:2*N+1], exp_v[2*N:N+1], exp_v[N]);
      else passes++;
      if (i == 1999) break;
      a = pick_operand(); b = pick_operand();
      exp_gap = (b == 0) ? 2 : N + 2;
      start = 1'b1; dividend = a; divisor = b;
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
        if (gap == 1) start = 1'b0;
      end while (!done && gap < 40);
      checks++;
      if (gap != exp_gap) begin
        $display("FAIL sweep_gap_%0d got %0d exp %0d", i, gap, exp_gap);
        if (!done) break;
      end else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_start_ignored();
    test_reset_mid();
    test_random_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
